lstm_bp_seq: RTL and testbench

LSTM_BP_SEQ -- requirements
Module: lstm_bp_seq

---
 rtl/lstm_bp_seq.sv | 124 ++++++++++++
 tb/tb_lstm_bp_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_bp_seq.sv
// rtl/lstm_bp_seq.sv - LSTM backprop training sequencer
// One sample = target load, then per-timestep wait/load/compute, then one weight write.
module lstm_bp_seq #(
  parameter int WIDTH          = 32,
  parameter int NUM_ITERATIONS = 8,
  parameter int WAIT_CYC       = 44,
  parameter int NUM_SAMPLES    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sel,
  output logic             o_load_in,
  output logic             o_load_h,
  output logic             o_load_bp,
  output logic             o_load_t,
  output logic [WIDTH-1:0] o_addr_t,
  output logic             o_wr,
  output logic [7:0]       o_step
);

  localparam int SW = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_TLOAD, S_WAIT, S_LDIN, S_CALC, S_WGAP, S_WR, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [7:0]       step_q, step_d;
  logic [SW-1:0]    sidx_q, sidx_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] addr_cur;

  // cnt_q doubles as the TLOAD beat index and the WAIT cycle counter.
  assign addr_cur = WIDTH'(sidx_q) * WIDTH'(NUM_ITERATIONS) + WIDTH'(cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      sidx_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      sidx_q  <= sidx_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    sidx_d  = sidx_q;
    addr_d  = addr_q;
    if (i_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            state_d = S_TLOAD;
            cnt_d   = '0;
            step_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_TLOAD: begin
          addr_d = addr_cur;
          if (cnt_q == 32'(NUM_ITERATIONS - 1)) begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_WAIT: begin
          if (cnt_q == 32'(WAIT_CYC - 1)) begin
            cnt_d   = '0;
            state_d = S_LDIN;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        S_LDIN: state_d = S_CALC;
        S_CALC: begin
          if (step_q < 8'(NUM_ITERATIONS - 1)) begin
            step_d  = step_q + 8'd1;
            state_d = S_WAIT;
          end else begin
            state_d = S_WGAP;
          end
        end
        S_WGAP: state_d = S_WR;
        S_WR: begin
          sidx_d  = (sidx_q == SW'(NUM_SAMPLES - 1)) ? '0 : sidx_q + SW'(1);
          state_d = S_DONE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = (state_q == S_DONE);
  assign o_sel     = (step_q != 8'd0);
  assign o_load_in = (state_q == S_LDIN);
  assign o_load_h  = (state_q == S_CALC);
  assign o_load_bp = (state_q == S_CALC);
  assign o_load_t  = (state_q == S_TLOAD);
  assign o_wr      = (state_q == S_WR);
  assign o_step    = step_q;
  // Address is live during TLOAD and otherwise holds the last beat.
  assign o_addr_t  = (state_q == S_TLOAD) ? addr_cur : addr_q;

endmodule

// File: tb/tb_lstm_bp_seq.sv
// tb/tb_lstm_bp_seq.sv - directed bench for lstm_bp_seq (default and single-step configs)
module tb_lstm_bp_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, abort = 1'b0;
  logic        start1 = 1'b0, abort1 = 1'b0;
  logic        busy, done, sel, load_in, load_h, load_bp, load_t, wr;
  logic [31:0] addr;
  logic [7:0]  step;
  logic        b_busy, b_done, b_sel, b_load_in, b_load_h, b_load_bp, b_load_t, b_wr;
  logic [31:0] b_addr;
  logic [7:0]  b_step;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  lstm_bp_seq #(.WIDTH(32), .NUM_ITERATIONS(8), .WAIT_CYC(44), .NUM_SAMPLES(2)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_sel(sel), .o_load_in(load_in),
    .o_load_h(load_h), .o_load_bp(load_bp), .o_load_t(load_t),
    .o_addr_t(addr), .o_wr(wr), .o_step(step)
  );

  lstm_bp_seq #(.WIDTH(32), .NUM_ITERATIONS(1), .WAIT_CYC(1), .NUM_SAMPLES(2)) dut1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_abort(abort1),
    .o_busy(b_busy), .o_done(b_done), .o_sel(b_sel), .o_load_in(b_load_in),
    .o_load_h(b_load_h), .o_load_bp(b_load_bp), .o_load_t(b_load_t),
    .o_addr_t(b_addr), .o_wr(b_wr), .o_step(b_step)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays cycles 0..ncyc-1 of a default-config sample against its timeline:
  // TLOAD 0..7, then 46-cycle steps (LDIN at +44, CALC at +45), WR 377, DONE 378.
  task automatic run_sample(input int base, input int ncyc, input string tag);
    logic [7:0]  exp_flags, got_flags;
    logic [31:0] exp_addr;
    logic [7:0]  exp_step;
    logic        e_in, e_h;
    int          r, k;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      e_in = 1'b0;
      e_h  = 1'b0;
      if (c < 8) begin
        exp_step = 8'd0;
      end else if (c < 376) begin
        r = (c - 8) % 46;
        k = (c - 8) / 46;
        exp_step = 8'(k);
        e_in = (r == 44);
        e_h  = (r == 45);
      end else begin
        exp_step = 8'd7;
      end
      exp_addr  = (c < 8) ? 32'(base + c) : 32'(base + 7);
      exp_flags = {1'b1, c == 378, exp_step != 8'd0, e_in, e_h, e_h, c < 8, c == 377};
      got_flags = {busy, done, sel, load_in, load_h, load_bp, load_t, wr};
      checks++;
      if (got_flags !== exp_flags) begin
        errors++;
        $display("FAIL %s flags cycle %0d: got %b expected %b", tag, c, got_flags, exp_flags);
      end
      checks++;
      if (addr !== exp_addr) begin
        errors++;
        $display("FAIL %s addr cycle %0d: got %0d expected %0d", tag, c, addr, exp_addr);
      end
      checks++;
      if (step !== exp_step) begin
        errors++;
        $display("FAIL %s step cycle %0d: got %0d expected %0d", tag, c, step, exp_step);
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({busy, done, sel, load_in, load_h, load_bp, load_t, wr, addr, step} !== 48'd0) begin
      errors++;
      $display("FAIL reset dut outputs: got %b/%0d/%0d expected 0",
               {busy, done, sel, load_in, load_h, load_bp, load_t, wr}, addr, step);
    end
    checks++;
    if ({b_busy, b_done, b_sel, b_load_in, b_load_h, b_load_bp, b_load_t, b_wr, b_addr, b_step} !== 48'd0) begin
      errors++;
      $display("FAIL reset dut1 outputs: got busy %b addr %0d step %0d expected 0", b_busy, b_addr, b_step);
    end
    tick();
  endtask

  task automatic test_single_sample();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_sample(0, 379, "single");
    @(negedge clk);
    checks++;
    if ({busy, done, wr} !== 3'b000) begin
      errors++;
      $display("FAIL single idle_after_done: got busy/done/wr %b expected 000", {busy, done, wr});
    end
    checks++;
    if (addr !== 32'd7) begin
      errors++;
      $display("FAIL single addr_hold: got %0d expected 7", addr);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    start = 1'b1;
    tick();
    run_sample(0, 379, "b2b_s0");
    run_sample(8, 379, "b2b_s1");
    start = 1'b0;
    run_sample(0, 379, "b2b_s2_wrap");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle_after_third: got busy %b expected 0", busy);
    end
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_vs_start_idle: got busy %b expected 0", busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    run_sample(0, 150, "abort_pre");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({busy, done, load_in, load_h, load_bp, load_t, wr} !== 7'd0) begin
        errors++;
        $display("FAIL abort_idle cycle %0d: got %b expected 0000000", i,
                 {busy, done, load_in, load_h, load_bp, load_t, wr});
      end
      tick();
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    run_sample(0, 10, "abort_restart");
    do_reset();
  endtask

  task automatic test_reset_in_wr();
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    run_sample(0, 377, "rstwr_pre");
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (wr !== 1'b1) begin
      errors++;
      $display("FAIL rstwr in_wr: got wr %b expected 1", wr);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, sel, load_in, load_h, load_bp, load_t, wr, addr, step} !== 48'd0) begin
      errors++;
      $display("FAIL rstwr outputs: got %b/%0d/%0d expected 0",
               {busy, done, sel, load_in, load_h, load_bp, load_t, wr}, addr, step);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    run_sample(0, 10, "rstwr_rerun");
    do_reset();
  endtask

  task automatic test_one_iteration();
    // {busy,done,sel,load_in,load_h,load_bp,load_t,wr} for TLOAD,WAIT,LDIN,CALC,WGAP,WR,DONE,IDLE
    logic [7:0] tbl [8] = '{8'b1000_0010, 8'b1000_0000, 8'b1001_0000, 8'b1000_1100,
                            8'b1000_0000, 8'b1000_0001, 8'b1100_0000, 8'b0000_0000};
    logic [7:0] got;
    for (int s = 0; s < 2; s++) begin
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        got = {b_busy, b_done, b_sel, b_load_in, b_load_h, b_load_bp, b_load_t, b_wr};
        checks++;
        if (got !== tbl[c]) begin
          errors++;
          $display("FAIL one_iter s%0d flags cycle %0d: got %b expected %b", s, c, got, tbl[c]);
        end
        checks++;
        if (b_addr !== 32'(s) || b_step !== 8'd0) begin
          errors++;
          $display("FAIL one_iter s%0d addr/step cycle %0d: got %0d/%0d expected %0d/0",
                   s, c, b_addr, b_step, s);
        end
        tick();
      end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_single_sample();
    test_back_to_back();
    test_abort();
    test_reset_in_wr();
    test_one_iteration();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
